// File: rtl/cva6_addx_unit.sv
// ADDX-family functional unit: full-width add, packed 8/16-bit lane adds (wrapping or
// signed-saturating) and a persistent accumulator, with configurable issue-to-writeback depth.
module cva6_addx_unit #(
    parameter int XLEN        = 32,
    parameter int NrStages    = 2,
    parameter int TransIdBits = 3,
    parameter bit SatEn       = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [2:0]             op_i,
    input  logic [XLEN-1:0]        rs1_i,
    input  logic [XLEN-1:0]        rs2_i,
    input  logic [TransIdBits-1:0] trans_id_i,
    output logic                   result_valid_o,
    output logic [XLEN-1:0]        result_o,
    output logic [TransIdBits-1:0] trans_id_o,
    output logic                   illegal_o,
    output logic [XLEN-1:0]        acc_o
);

    localparam logic [2:0] OpAdd     = 3'd0;
    localparam logic [2:0] OpPadd8   = 3'd1;
    localparam logic [2:0] OpPadd16  = 3'd2;
    localparam logic [2:0] OpPadds8  = 3'd3;
    localparam logic [2:0] OpPadds16 = 3'd4;
    localparam logic [2:0] OpAcc     = 3'd5;
    localparam logic [2:0] OpAccClr  = 3'd6;

    // For ACC the data field carries rs1+rs2; the accumulator is only added in the final stage.
    typedef struct packed {
        logic                   valid;
        logic                   illegal;
        logic                   is_acc;
        logic                   is_clr;
        logic [TransIdBits-1:0] tid;
        logic [XLEN-1:0]        data;
    } stage_t;

    function automatic logic [XLEN-1:0] lane_add8(input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b,
                                                  input logic            sat);
        logic [XLEN-1:0] r;
        logic [8:0]      s;
        r = '0;
        for (int i = 0; i < XLEN / 8; i++) begin
            s = {a[8*i+7], a[8*i +: 8]} + {b[8*i+7], b[8*i +: 8]};
            if (sat && (s[8] != s[7])) begin
                r[8*i +: 8] = s[8] ? 8'h80 : 8'h7F;
            end else begin
                r[8*i +: 8] = s[7:0];
            end
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] lane_add16(input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b,
                                                   input logic            sat);
        logic [XLEN-1:0] r;
        logic [16:0]     s;
        r = '0;
        for (int i = 0; i < XLEN / 16; i++) begin
            s = {a[16*i+15], a[16*i +: 16]} + {b[16*i+15], b[16*i +: 16]};
            if (sat && (s[16] != s[15])) begin
                r[16*i +: 16] = s[16] ? 16'h8000 : 16'h7FFF;
            end else begin
                r[16*i +: 16] = s[15:0];
            end
        end
        return r;
    endfunction

    stage_t          issue_s;
    stage_t          final_in_s;
    logic            acc_busy_s;
    logic [XLEN-1:0] acc_r;
    logic [XLEN-1:0] acc_sum_s;
    logic [XLEN-1:0] wb_result_s;
    logic [XLEN-1:0] acc_next_s;

    assign ready_o = rst_ni & ~flush_i & ~acc_busy_s;

    // Stage-1 decode and lane arithmetic for the op being accepted this cycle.
    always_comb begin
        issue_s       = '0;
        issue_s.valid = valid_i & ready_o;
        issue_s.tid   = trans_id_i;
        case (op_i)
            OpAdd:    issue_s.data = rs1_i + rs2_i;
            OpPadd8:  issue_s.data = lane_add8(rs1_i, rs2_i, 1'b0);
            OpPadd16: issue_s.data = lane_add16(rs1_i, rs2_i, 1'b0);
            OpPadds8: begin
                if (SatEn) begin
                    issue_s.data = lane_add8(rs1_i, rs2_i, 1'b1);
                end else begin
                    issue_s.illegal = 1'b1;
                end
            end
            OpPadds16: begin
                if (SatEn) begin
                    issue_s.data = lane_add16(rs1_i, rs2_i, 1'b1);
                end else begin
                    issue_s.illegal = 1'b1;
                end
            end
            OpAcc: begin
                issue_s.is_acc = 1'b1;
                issue_s.data   = rs1_i + rs2_i;
            end
            OpAccClr: issue_s.is_clr = 1'b1;
            default:  issue_s.illegal = 1'b1;
        endcase
    end

    // With a single stage the output register is stage 1; otherwise NrStages-1 delay registers
    // precede it and any accumulator op held there blocks issue.
    if (NrStages == 1) begin : g_direct
        assign final_in_s = issue_s;
        assign acc_busy_s = 1'b0;
    end else begin : g_pipe
        stage_t pipe_r [NrStages-1];

        // Delay line; reset and flush kill every in-flight op.
        always_ff @(posedge clk_i) begin
            if (!rst_ni || flush_i) begin
                for (int i = 0; i < NrStages - 1; i++) begin
                    pipe_r[i] <= '0;
                end
            end else begin
                pipe_r[0] <= issue_s;
                for (int i = 1; i < NrStages - 1; i++) begin
                    pipe_r[i] <= pipe_r[i-1];
                end
            end
        end

        // Accumulator hazard: hold issue while an ACC-type op has not yet written back.
        always_comb begin
            acc_busy_s = 1'b0;
            for (int i = 0; i < NrStages - 1; i++) begin
                acc_busy_s = acc_busy_s |
                             (pipe_r[i].valid & (pipe_r[i].is_acc | pipe_r[i].is_clr));
            end
        end

        assign final_in_s = pipe_r[NrStages-2];
    end

    // Final-stage accumulator read-modify-write and writeback value selection.
    always_comb begin
        acc_sum_s = acc_r + final_in_s.data;
        if (final_in_s.is_acc) begin
            wb_result_s = acc_sum_s;
            acc_next_s  = acc_sum_s;
        end else if (final_in_s.is_clr) begin
            wb_result_s = acc_r;
            acc_next_s  = '0;
        end else begin
            wb_result_s = final_in_s.data;
            acc_next_s  = acc_r;
        end
    end

    // Writeback registers and committed accumulator; acc_o trails acc_r by one cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            result_valid_o <= 1'b0;
            result_o       <= '0;
            trans_id_o     <= '0;
            illegal_o      <= 1'b0;
            acc_r          <= '0;
            acc_o          <= '0;
        end else begin
            acc_o <= acc_r;
            if (flush_i) begin
                result_valid_o <= 1'b0;
                illegal_o      <= 1'b0;
            end else begin
                result_valid_o <= final_in_s.valid;
                illegal_o      <= final_in_s.valid & final_in_s.illegal;
                if (final_in_s.valid) begin
                    result_o   <= wb_result_s;
                    trans_id_o <= final_in_s.tid;
                    acc_r      <= acc_next_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_cva6_addx_unit.sv
// Directed bench for cva6_addx_unit: three configurations (32b/2 stages, 64b/4 stages without
// saturation, 64b/1 stage) driven one at a time from a shared clock, reset and flush.
module tb_cva6_addx_unit;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        va, vb, vc;
    logic [2:0]  op, tid;
    logic [63:0] rs1, rs2;

    logic        a_ready, a_rv, a_ill;
    logic [31:0] a_res, a_acc;
    logic [2:0]  a_tid;
    logic        b_ready, b_rv, b_ill;
    logic [63:0] b_res, b_acc;
    logic [2:0]  b_tid;
    logic        c_ready, c_rv, c_ill;
    logic [63:0] c_res, c_acc;
    logic [2:0]  c_tid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cva6_addx_unit #(.XLEN(32), .NrStages(2), .TransIdBits(3), .SatEn(1'b1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(va), .ready_o(a_ready),
        .op_i(op), .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .trans_id_i(tid),
        .result_valid_o(a_rv), .result_o(a_res), .trans_id_o(a_tid), .illegal_o(a_ill),
        .acc_o(a_acc));

    cva6_addx_unit #(.XLEN(64), .NrStages(4), .TransIdBits(3), .SatEn(1'b0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(vb), .ready_o(b_ready),
        .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .trans_id_i(tid),
        .result_valid_o(b_rv), .result_o(b_res), .trans_id_o(b_tid), .illegal_o(b_ill),
        .acc_o(b_acc));

    cva6_addx_unit #(.XLEN(64), .NrStages(1), .TransIdBits(3), .SatEn(1'b1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(vc), .ready_o(c_ready),
        .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .trans_id_i(tid),
        .result_valid_o(c_rv), .result_o(c_res), .trans_id_o(c_tid), .illegal_o(c_ill),
        .acc_o(c_acc));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; va = 1'b0; vb = 1'b0; vc = 1'b0;
        op = 3'd0; tid = 3'd0; rs1 = 64'h0; rs2 = 64'h0;
        step(); step();
        chk("rst_a_ready", 64'(a_ready), 64'h0);
        chk("rst_a_rv", 64'(a_rv), 64'h0);
        chk("rst_a_res", 64'(a_res), 64'h0);
        chk("rst_a_tid", 64'(a_tid), 64'h0);
        chk("rst_a_ill", 64'(a_ill), 64'h0);
        chk("rst_a_acc", 64'(a_acc), 64'h0);
        chk("rst_b_rv", 64'(b_rv), 64'h0);
        chk("rst_c_rv", 64'(c_rv), 64'h0);
        rst_n = 1'b1;

        // A: ADD wraps, two-cycle latency
        va = 1'b1; op = 3'd0; rs1 = 64'hFFFF_FFFF; rs2 = 64'h2; tid = 3'd3; #1;
        chk("a_add_ready", 64'(a_ready), 64'h1);
        step(); va = 1'b0;
        chk("a_add_early", 64'(a_rv), 64'h0);
        step();
        chk("a_add_rv", 64'(a_rv), 64'h1);
        chk("a_add_res", 64'(a_res), 64'h1);
        chk("a_add_tid", 64'(a_tid), 64'h3);
        chk("a_add_ill", 64'(a_ill), 64'h0);

        // A: PADD8 then PADDS8 back to back
        va = 1'b1; op = 3'd1; rs1 = 64'h7F01_FF80; rs2 = 64'h0101_0180; tid = 3'd1;
        step(); op = 3'd3; tid = 3'd2;
        step(); va = 1'b0;
        chk("a_padd8_res", 64'(a_res), 64'h8002_0000);
        chk("a_padd8_tid", 64'(a_tid), 64'h1);
        step();
        chk("a_padds8_rv", 64'(a_rv), 64'h1);
        chk("a_padds8_res", 64'(a_res), 64'h7F02_0080);
        chk("a_padds8_tid", 64'(a_tid), 64'h2);

        // A: PADDS16 clamps both lanes, then reserved op 7
        va = 1'b1; op = 3'd4; rs1 = 64'h7FFF_8000; rs2 = 64'h0001_FFFF; tid = 3'd4;
        step(); op = 3'd7; tid = 3'd5;
        step(); va = 1'b0;
        chk("a_padds16_res", 64'(a_res), 64'h7FFF_8000);
        chk("a_padds16_ill", 64'(a_ill), 64'h0);
        step();
        chk("a_op7_rv", 64'(a_rv), 64'h1);
        chk("a_op7_res", 64'(a_res), 64'h0);
        chk("a_op7_ill", 64'(a_ill), 64'h1);
        chk("a_op7_tid", 64'(a_tid), 64'h5);
        step();
        chk("a_idle_rv", 64'(a_rv), 64'h0);

        // A: accumulator hazard and clear
        va = 1'b1; op = 3'd5; rs1 = 64'd5; rs2 = 64'd7; tid = 3'd6;
        step(); rs1 = 64'd1; rs2 = 64'd1; tid = 3'd7; #1;
        chk("a_acc_stall", 64'(a_ready), 64'h0);
        step();
        chk("a_acc1_rv", 64'(a_rv), 64'h1);
        chk("a_acc1_res", 64'(a_res), 64'd12);
        chk("a_acc1_tid", 64'(a_tid), 64'h6);
        chk("a_acc1_ready", 64'(a_ready), 64'h1);
        chk("a_acc1_acco", 64'(a_acc), 64'h0);
        step(); va = 1'b0;
        chk("a_acc2_stall", 64'(a_ready), 64'h0);
        chk("a_acc2_gap", 64'(a_rv), 64'h0);
        chk("a_acco_12", 64'(a_acc), 64'd12);
        step();
        chk("a_acc2_res", 64'(a_res), 64'd14);
        chk("a_acc2_tid", 64'(a_tid), 64'h7);
        va = 1'b1; op = 3'd6; tid = 3'd0;
        step(); va = 1'b0;
        chk("a_clr_stall", 64'(a_ready), 64'h0);
        chk("a_acco_14", 64'(a_acc), 64'd14);
        step();
        chk("a_clr_rv", 64'(a_rv), 64'h1);
        chk("a_clr_res", 64'(a_res), 64'd14);
        step();
        chk("a_clr_acco", 64'(a_acc), 64'h0);

        // A: flush kills an in-flight ACC
        va = 1'b1; op = 3'd5; rs1 = 64'd10; rs2 = 64'd0; tid = 3'd2;
        step(); va = 1'b0; flush = 1'b1; #1;
        chk("a_flush_ready", 64'(a_ready), 64'h0);
        step(); flush = 1'b0; #1;
        chk("a_post_flush_ready", 64'(a_ready), 64'h1);
        chk("a_post_flush_rv", 64'(a_rv), 64'h0);
        step();
        chk("a_flush_no_wb", 64'(a_rv), 64'h0);
        step();
        chk("a_flush_acco", 64'(a_acc), 64'h0);

        // B: 64-bit ADD with four-cycle latency
        vb = 1'b1; op = 3'd0; rs1 = 64'hFFFF_FFFF_FFFF_FFFF; rs2 = 64'h2; tid = 3'd3;
        step(); vb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("b_add_early", 64'(b_rv), 64'h0);
            step();
        end
        chk("b_add_rv", 64'(b_rv), 64'h1);
        chk("b_add_res", b_res, 64'h1);
        chk("b_add_tid", 64'(b_tid), 64'h3);

        // B: four-lane PADD16, then PADDS16 illegal without saturation support
        vb = 1'b1; op = 3'd2; rs1 = 64'hFFFF_0001_7FFF_8000; rs2 = 64'h0001_0001_0001_8000;
        tid = 3'd1;
        step(); op = 3'd4; tid = 3'd2;
        step(); vb = 1'b0;
        step(); step();
        chk("b_padd16_res", b_res, 64'h0000_0002_8000_0000);
        chk("b_padd16_ill", 64'(b_ill), 64'h0);
        step();
        chk("b_padds16_rv", 64'(b_rv), 64'h1);
        chk("b_padds16_res", b_res, 64'h0);
        chk("b_padds16_ill", 64'(b_ill), 64'h1);
        chk("b_padds16_tid", 64'(b_tid), 64'h2);

        // B: ACC stalls issue for three cycles
        vb = 1'b1; op = 3'd5; rs1 = 64'd5; rs2 = 64'd7; tid = 3'd1;
        step(); rs1 = 64'd1; rs2 = 64'd1; tid = 3'd2; #1;
        chk("b_stall1", 64'(b_ready), 64'h0);
        step();
        chk("b_stall2", 64'(b_ready), 64'h0);
        step();
        chk("b_stall3", 64'(b_ready), 64'h0);
        step();
        chk("b_acc1_rv", 64'(b_rv), 64'h1);
        chk("b_acc1_res", b_res, 64'd12);
        chk("b_acc1_ready", 64'(b_ready), 64'h1);
        step(); vb = 1'b0; op = 3'd0;
        chk("b_acc2_stall", 64'(b_ready), 64'h0);
        chk("b_acco_12", b_acc, 64'd12);
        step(); step(); step();
        chk("b_acc2_res", b_res, 64'd14);
        chk("b_acc2_tid", 64'(b_tid), 64'h2);

        // B: reset with two ADDs in flight
        vb = 1'b1; rs1 = 64'd1; rs2 = 64'd1; tid = 3'd4;
        step(); tid = 3'd5;
        step(); vb = 1'b0; rst_n = 1'b0;
        step(); rst_n = 1'b1;
        chk("b_rst_rv", 64'(b_rv), 64'h0);
        chk("b_rst_res", b_res, 64'h0);
        chk("b_rst_tid", 64'(b_tid), 64'h0);
        chk("b_rst_ill", 64'(b_ill), 64'h0);
        chk("b_rst_acc", b_acc, 64'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("b_rst_no_wb", 64'(b_rv), 64'h0);
        end

        // C: single-stage ADD and 64-bit PADDS8
        vc = 1'b1; op = 3'd0; rs1 = 64'hFFFF_FFFF_FFFF_FFFF; rs2 = 64'h2; tid = 3'd3; #1;
        chk("c_ready", 64'(c_ready), 64'h1);
        step();
        chk("c_add_rv", 64'(c_rv), 64'h1);
        chk("c_add_res", c_res, 64'h1);
        chk("c_add_tid", 64'(c_tid), 64'h3);
        op = 3'd3; rs1 = 64'h7F01_FF80_7F01_FF80; rs2 = 64'h0101_0180_0101_0180; tid = 3'd4;
        step();
        chk("c_padds8_res", c_res, 64'h7F02_0080_7F02_0080);
        chk("c_padds8_ill", 64'(c_ill), 64'h0);

        // C: back-to-back ACC without stalls, then clear
        op = 3'd5; rs1 = 64'd5; rs2 = 64'd7; tid = 3'd1;
        step();
        chk("c_acc1_res", c_res, 64'd12);
        chk("c_acc_no_stall", 64'(c_ready), 64'h1);
        rs1 = 64'd1; rs2 = 64'd1; tid = 3'd2;
        step();
        chk("c_acc2_res", c_res, 64'd14);
        chk("c_acco_12", c_acc, 64'd12);
        op = 3'd6; tid = 3'd3;
        step(); vc = 1'b0;
        chk("c_clr_rv", 64'(c_rv), 64'h1);
        chk("c_clr_res", c_res, 64'd14);
        step();
        chk("c_clr_acco", c_acc, 64'h0);
        chk("c_idle_rv", 64'(c_rv), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
